// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port, synchronous-read memory.
// Core (C) normally wins; debug (D) has a starvation bound and a locked burst mode.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  c_req_valid,
    output logic                  c_req_ready,
    input  logic [ADDR_W-1:0]     c_req_addr,
    input  logic [DATA_W-1:0]     c_req_wdata,
    input  logic                  c_req_we,
    input  logic [DATA_W/8-1:0]   c_req_be,
    output logic                  c_rsp_valid,
    output logic [DATA_W-1:0]     c_rsp_rdata,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_W-1:0]     d_req_addr,
    input  logic [DATA_W-1:0]     d_req_wdata,
    input  logic                  d_req_we,
    input  logic [DATA_W/8-1:0]   d_req_be,
    input  logic                  d_req_lock,
    output logic                  d_rsp_valid,
    output logic [DATA_W-1:0]     d_rsp_rdata,

    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  dbg_locked
);

    localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

    typedef enum logic [0:0] {StArb, StLock} state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             rsp_owner_c_q, rsp_owner_c_d;
    logic             rsp_owner_d_q, rsp_owner_d_d;
    logic             gnt_c, gnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StArb;
            wait_cnt_q    <= '0;
            rsp_owner_c_q <= 1'b0;
            rsp_owner_d_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_owner_c_q <= rsp_owner_c_d;
            rsp_owner_d_q <= rsp_owner_d_d;
        end
    end

    // Any D grant decides the next state from its lock bit, in either state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StArb:   if (gnt_d && d_req_lock)  state_d = StLock;
            StLock:  if (gnt_d && !d_req_lock) state_d = StArb;
            default: state_d = StArb;
        endcase
    end

    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        unique case (state_q)
            StArb: begin
                gnt_d = d_req_valid & (~c_req_valid | (wait_cnt_q >= WaitMax));
                gnt_c = c_req_valid & ~gnt_d;
            end
            StLock:  gnt_d = d_req_valid;
            default: ;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (gnt_d) begin
            wait_cnt_d = '0;
        end else if (d_req_valid && (wait_cnt_q < WaitMax)) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
    end

    // Memory reads take one cycle, so the owner flag lines up with mem_rdata.
    always_comb begin
        rsp_owner_c_d = gnt_c;
        rsp_owner_d_d = gnt_d;
    end

    assign c_req_ready = gnt_c;
    assign d_req_ready = gnt_d;

    assign mem_addr  = gnt_d ? d_req_addr  : c_req_addr;
    assign mem_wdata = gnt_d ? d_req_wdata : c_req_wdata;
    assign mem_be    = gnt_d ? d_req_be    : c_req_be;
    assign mem_we    = (gnt_c & c_req_we) | (gnt_d & d_req_we);

    assign c_rsp_valid = rsp_owner_c_q;
    assign d_rsp_valid = rsp_owner_d_q;
    assign c_rsp_rdata = mem_rdata;
    assign d_rsp_rdata = mem_rdata;

    assign dbg_locked = (state_q == StLock);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory, reference memory model and a
// per-requester response scoreboard.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req_valid, c_req_ready, c_req_we, c_rsp_valid;
    logic [AW-1:0] c_req_addr;
    logic [DW-1:0] c_req_wdata, c_rsp_rdata;
    logic [3:0]    c_req_be;
    logic          d_req_valid, d_req_ready, d_req_we, d_req_lock, d_rsp_valid;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata, d_rsp_rdata;
    logic [3:0]    d_req_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic          dbg_locked;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        c_q[$];
    exp_t        d_q[$];
    logic [31:0] mem_arr[int];
    logic [31:0] ref_arr[int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    mem_port_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .c_req_valid (c_req_valid),
        .c_req_ready (c_req_ready),
        .c_req_addr  (c_req_addr),
        .c_req_wdata (c_req_wdata),
        .c_req_we    (c_req_we),
        .c_req_be    (c_req_be),
        .c_rsp_valid (c_rsp_valid),
        .c_rsp_rdata (c_rsp_rdata),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_req_addr  (d_req_addr),
        .d_req_wdata (d_req_wdata),
        .d_req_we    (d_req_we),
        .d_req_be    (d_req_be),
        .d_req_lock  (d_req_lock),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_rdata (d_rsp_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_rdata   (mem_rdata),
        .dbg_locked  (dbg_locked)
    );

    function automatic logic [31:0] init_word(input logic [7:0] i);
        return {8'hA5, i, ~i, i ^ 8'h3C};
    endfunction

    // Read-first synchronous memory driven only by the DUT's mem_* outputs.
    always @(posedge clk) begin : mem_model
        logic [31:0] old_w;
        logic [31:0] new_w;
        int          w;
        w     = int'(mem_addr[9:2]);
        old_w = mem_arr.exists(w) ? mem_arr[w] : init_word(mem_addr[9:2]);
        new_w = old_w;
        for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) new_w[8*b +: 8] = mem_wdata[8*b +: 8];
        end
        if (mem_we) mem_arr[w] = new_w;
        mem_rdata <= old_w;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t make_exp(input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] be);
        exp_t        e;
        int          w;
        logic [31:0] v;
        w = int'(addr[9:2]);
        v = ref_arr.exists(w) ? ref_arr[w] : init_word(addr[9:2]);
        e.rd   = !we;
        e.data = v;
        e.cyc  = cyc_cnt;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) v[8*b +: 8] = wdata[8*b +: 8];
            end
            ref_arr[w] = v;
        end
        return e;
    endfunction

    // A response is due exactly one cycle after its grant was pushed.
    always @(negedge clk) begin : rsp_mon
        exp_t e;
        bit   due;
        due = (c_q.size() != 0) && (c_q[0].cyc < cyc_cnt);
        check("c_rsp_valid", 32'(c_rsp_valid), 32'(due));
        if (due) begin
            e = c_q.pop_front();
            if (e.rd && c_rsp_valid) check("c_rsp_rdata", c_rsp_rdata, e.data);
        end
        due = (d_q.size() != 0) && (d_q[0].cyc < cyc_cnt);
        check("d_rsp_valid", 32'(d_rsp_valid), 32'(due));
        if (due) begin
            e = d_q.pop_front();
            if (e.rd && d_rsp_valid) check("d_rsp_rdata", d_rsp_rdata, e.data);
        end
    end

    task automatic set_c(input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        c_req_valid = v;
        c_req_we    = we;
        c_req_addr  = a;
        c_req_wdata = wd;
        c_req_be    = be;
    endtask

    task automatic set_d(input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input logic lk);
        d_req_valid = v;
        d_req_we    = we;
        d_req_addr  = a;
        d_req_wdata = wd;
        d_req_be    = be;
        d_req_lock  = lk;
    endtask

    task automatic tick(input bit ec, input bit ed, input bit el, input bit push);
        @(negedge clk);
        check("c_req_ready", 32'(c_req_ready), 32'(ec));
        check("d_req_ready", 32'(d_req_ready), 32'(ed));
        check("dbg_locked", 32'(dbg_locked), 32'(el));
        check("mem_we", 32'(mem_we), 32'((ec & c_req_we) | (ed & d_req_we)));
        if (push && ec) c_q.push_back(make_exp(c_req_we, c_req_addr, c_req_wdata, c_req_be));
        if (push && ed) d_q.push_back(make_exp(d_req_we, d_req_addr, d_req_wdata, d_req_be));
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        int kc;
        rst = 1'b1;
        set_c(0, 0, 0, 0, 0);
        set_d(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_dbg_locked", 32'(dbg_locked), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // C-only back-to-back reads.
        for (int i = 0; i < 3; i++) begin
            set_c(1, 0, 32'(4 * i), 0, 4'hF);
            tick(1, 0, 0, 1);
        end
        set_c(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1);

        // D write with C idle, then C reads it back.
        set_d(1, 1, 32'h40, 32'hDEADBEEF, 4'hF, 0);
        tick(0, 1, 0, 1);
        set_d(0, 0, 0, 0, 0, 0);
        set_c(1, 0, 32'h40, 0, 4'hF);
        tick(1, 0, 0, 1);

        // Partial-byte D write merges into the old word.
        set_c(0, 0, 0, 0, 0);
        set_d(1, 1, 32'h50, 32'h11223344, 4'hF, 0);
        tick(0, 1, 0, 1);
        set_d(1, 1, 32'h50, 32'h0000ABCD, 4'h3, 0);
        tick(0, 1, 0, 1);
        set_d(0, 0, 0, 0, 0, 0);
        set_c(1, 0, 32'h50, 0, 4'hF);
        tick(1, 0, 0, 1);
        check("merge_word", ref_arr[int'(32'h50 >> 2)], 32'h1122ABCD);

        // Contention: D forced through after MAX_WAIT C grants, twice in a row.
        kc = 0;
        set_c(1, 0, 32'h10, 0, 4'hF);
        set_d(1, 0, 32'h20, 0, 4'hF, 0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < int'(MW); i++) begin
                tick(1, 0, 0, 1);
                kc++;
                set_c(1, 0, 32'h10 + 32'(4 * (kc % 4)), 0, 4'hF);
            end
            tick(0, 1, 0, 1);
            set_d(1, 0, 32'h24, 0, 4'hF, 0);
        end
        set_d(0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 1);
        set_c(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1);

        // Locked D burst with C waiting throughout, including a D idle gap.
        set_d(1, 1, 32'h80, 32'h000000B0, 4'hF, 1);
        tick(0, 1, 0, 1);
        set_c(1, 0, 32'h80, 0, 4'hF);
        set_d(1, 1, 32'h84, 32'h000000B4, 4'hF, 1);
        tick(0, 1, 1, 1);
        set_d(0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 1);
        set_d(1, 1, 32'h88, 32'h000000B8, 4'hF, 1);
        tick(0, 1, 1, 1);
        set_d(1, 1, 32'h8C, 32'h000000BC, 4'hF, 0);
        tick(0, 1, 1, 1);
        set_d(0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 1);
        set_c(1, 0, 32'h8C, 0, 4'hF);
        tick(1, 0, 0, 1);
        set_c(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1);

        // Reset right after a C grant drops its response.
        set_c(1, 0, 32'h04, 0, 4'hF);
        tick(1, 0, 0, 0);
        set_c(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("rst_drop_c_rsp", 32'(c_rsp_valid), 32'd0);
        #1;
        rst = 1'b0;
        tick(0, 0, 0, 1);

        // Reset during LOCK releases it; C is granted straight after.
        set_d(1, 1, 32'h90, 32'h12345678, 4'hF, 1);
        tick(0, 1, 0, 1);
        set_d(0, 0, 0, 0, 0, 0);
        set_c(1, 0, 32'h90, 0, 4'hF);
        tick(0, 0, 1, 1);
        rst = 1'b1;
        #1;
        check("rst_unlock", 32'(dbg_locked), 32'd0);
        #1;
        rst = 1'b0;
        tick(1, 0, 0, 1);
        set_c(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);

        check("c_q_drained", 32'(c_q.size()), 32'd0);
        check("d_q_drained", 32'(d_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
